// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED controller: shared tick prescaler plus one
// independent off/on/blink/activity engine per LED channel.

module led_status_ch #(
    parameter int HALF_W        = 10,
    parameter int STRETCH_TICKS = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        mode,
    input  logic [HALF_W-1:0] half_period,
    input  logic              evt,
    output logic              led_on
);
    localparam int ST_W = $clog2(STRETCH_TICKS + 1);
    localparam int CW   = (HALF_W > ST_W) ? HALF_W : ST_W;
    localparam logic [CW-1:0] ST_LAST = CW'(STRETCH_TICKS - 1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_ACT   = 2'd3;

    typedef enum logic [1:0] {IDLE, FLASH, GAP} act_st_t;

    act_st_t       st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hp_last;
    logic          pend;
    logic [1:0]    prev_mode;

    // half_period of 0 behaves as 1; >= compare lets a shrink land on the next tick
    assign hp_last = (half_period == '0) ? '0 : CW'(half_period - HALF_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            prev_mode <= M_OFF;
            led_on    <= 1'b0;
        end else if (mode != prev_mode) begin
            prev_mode <= mode;
            cnt       <= '0;
            pend      <= 1'b0;
            st        <= IDLE;
            led_on    <= (mode == M_ON) || (mode == M_BLINK);
        end else begin
            case (mode)
                M_OFF: led_on <= 1'b0;
                M_ON:  led_on <= 1'b1;
                M_BLINK: begin
                    if (tick) begin
                        if (cnt >= hp_last) begin
                            cnt    <= '0;
                            led_on <= ~led_on;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                M_ACT: begin
                    case (st)
                        IDLE: begin
                            led_on <= 1'b0;
                            pend   <= 1'b0;
                            if (evt) begin
                                st     <= FLASH;
                                cnt    <= '0;
                                led_on <= 1'b1;
                            end
                        end
                        FLASH: begin
                            if (evt) pend <= 1'b1;
                            if (tick) begin
                                if (cnt == ST_LAST) begin
                                    st     <= GAP;
                                    cnt    <= '0;
                                    led_on <= 1'b0;
                                end else begin
                                    cnt <= cnt + CW'(1);
                                end
                            end
                        end
                        GAP: begin
                            if (evt) pend <= 1'b1;
                            if (tick) begin
                                if (cnt == ST_LAST) begin
                                    cnt <= '0;
                                    // an event landing on the re-flash edge stays queued
                                    if (pend) begin
                                        st     <= FLASH;
                                        led_on <= 1'b1;
                                        pend   <= evt;
                                    end else begin
                                        st <= IDLE;
                                    end
                                end else begin
                                    cnt <= cnt + CW'(1);
                                end
                            end
                        end
                        default: st <= IDLE;
                    endcase
                end
                default: led_on <= 1'b0;
            endcase
        end
    end
endmodule

module led_status_ctrl #(
    parameter int CHANNELS      = 4,
    parameter int PRESCALE      = 25_000,
    parameter int HALF_W        = 10,
    parameter int STRETCH_TICKS = 50,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0][1:0]         mode,
    input  logic [CHANNELS-1:0][HALF_W-1:0]  half_period,
    input  logic [CHANNELS-1:0]              evt,
    output logic [CHANNELS-1:0]              led,
    output logic                             tick
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       pre_cnt;
    logic [CHANNELS-1:0] led_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        led_status_ch #(
            .HALF_W        (HALF_W),
            .STRETCH_TICKS (STRETCH_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .mode        (mode[gi]),
            .half_period (half_period[gi]),
            .evt         (evt[gi]),
            .led_on      (led_on[gi])
        );
    end

    assign led = led_on ^ {CHANNELS{ACTIVE_LOW}};
endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: directed stimulus pushes expected
// led/tick per cycle; a monitor pops and compares both polarity variants.

module tb_led_status_ctrl;
    localparam int CH = 2, PS = 4, ST = 3, HW = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [CH-1:0][1:0]      mode;
    logic [CH-1:0][HW-1:0]   hp;
    logic [CH-1:0]           evt;
    logic [CH-1:0]           led, led_n;
    logic                    tick, tick_n;

    led_status_ctrl #(.CHANNELS(CH), .PRESCALE(PS), .HALF_W(HW),
                      .STRETCH_TICKS(ST), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .half_period(hp),
        .evt(evt), .led(led), .tick(tick));

    led_status_ctrl #(.CHANNELS(CH), .PRESCALE(PS), .HALF_W(HW),
                      .STRETCH_TICKS(ST), .ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .rst(rst), .mode(mode), .half_period(hp),
        .evt(evt), .led(led_n), .tick(tick_n));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       async_chk;
        logic [1:0] led;
        logic       tick_care;
        logic       tick;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    int   c0 = 0;
    event sample_ev;

    // ch0 free-runs a half_period=1 blink from r=45 through r=221
    function automatic logic b0(input int r);
        return ((((r - 45) / 4) % 2) == 0);
    endfunction

    task automatic push(input int at, input logic async_chk, input logic [1:0] l,
                        input logic care, input logic t, input string nm);
        exp_t e;
        e.at = c0 + at; e.async_chk = async_chk; e.led = l;
        e.tick_care = care; e.tick = t; e.name = $sformatf("%s@%0d", nm, at);
        sb.push_back(e);
    endtask

    task automatic ex(input int at, input logic [1:0] l, input string nm);
        push(at, 1'b0, l, 1'b0, 1'b0, nm);
    endtask

    task automatic ext(input int at, input logic [1:0] l, input logic t, input string nm);
        push(at, 1'b0, l, 1'b1, t, nm);
    endtask

    task automatic exa(input int at, input logic ch1, input string nm);
        ex(at, {ch1, b0(at)}, nm);
    endtask

    task automatic cmp(input exp_t e);
        n_chk++;
        if (led === e.led) n_pass++;
        else $display("FAIL %s led got %b want %b", e.name, led, e.led);
        n_chk++;
        if (led_n === ~e.led) n_pass++;
        else $display("FAIL %s led_n got %b want %b", e.name, led_n, ~e.led);
        if (e.tick_care) begin
            n_chk++;
            if (tick === e.tick && tick_n === e.tick) n_pass++;
            else $display("FAIL %s tick got %b/%b want %b", e.name, tick, tick_n, e.tick);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or sample_ev);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].async_chk) begin
                    cmp(sb[i]);
                    sb.delete(i);
                end else if (clk == 1'b0 && sb[i].at == cyc) begin
                    cmp(sb[i]);
                    sb.delete(i);
                end else if (clk == 1'b0 && sb[i].at < cyc) begin
                    n_chk++;
                    $display("FAIL %s missed at cycle %0d", sb[i].name, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic go(input int at);
        while (cyc - c0 < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        mode = '0; hp = '0; evt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        c0  = cyc;

        // reset state and tick cadence
        ext(0, 2'b00, 1'b0, "rst"); ext(1, 2'b00, 1'b0, "tick");
        ext(2, 2'b00, 1'b0, "tick"); ext(3, 2'b00, 1'b0, "tick");
        ext(4, 2'b00, 1'b1, "tick_first"); ext(5, 2'b00, 1'b0, "tick");
        ext(7, 2'b00, 1'b0, "tick"); ext(8, 2'b00, 1'b1, "tick_second");

        go(8); mode[0] = 2'd2; hp[0] = 4'd2;
        ext(9, 2'b01, 1'b0, "blink_entry"); ext(12, 2'b01, 1'b1, "blink_hold");
        ext(16, 2'b01, 1'b1, "blink_hold"); ex(17, 2'b00, "blink_t1");
        ext(24, 2'b00, 1'b1, "blink_hold"); ex(25, 2'b01, "blink_t2");

        go(25); hp[0] = 4'd0;
        ex(28, 2'b01, "hp0_hold"); ex(29, 2'b00, "hp0_t1"); ex(32, 2'b00, "hp0_hold");
        ex(33, 2'b01, "hp0_t2"); ex(37, 2'b00, "hp0_t3");

        go(37); hp[0] = 4'd3;
        ex(41, 2'b00, "hp3_count"); ex(44, 2'b00, "hp_shrink_hold");
        ex(45, 2'b01, "hp_shrink"); ex(49, 2'b00, "hp1_next");
        go(41); hp[0] = 4'd1;

        go(49); mode[1] = 2'd3;
        exa(50, 1'b0, "act_entry"); exa(51, 1'b1, "act_flash"); exa(60, 1'b1, "act_flash_end");
        exa(61, 1'b0, "act_gap"); exa(72, 1'b0, "act_gap"); exa(73, 1'b0, "act_idle");
        exa(74, 1'b1, "act_reflash"); exa(84, 1'b1, "pend_flash"); exa(85, 1'b0, "pend_gap");
        exa(96, 1'b0, "pend_gap_end"); exa(97, 1'b1, "pend_relight"); exa(108, 1'b1, "pend_flash2");
        exa(109, 1'b0, "pend_gap2"); exa(121, 1'b0, "pend_idle");
        go(50); evt[1] = 1'b1; go(51); evt[1] = 1'b0;
        go(73); evt[1] = 1'b1; go(74); evt[1] = 1'b0;
        go(78); evt[1] = 1'b1; go(79); evt[1] = 1'b0;

        go(121); evt[1] = 1'b1;
        exa(122, 1'b1, "cont_on"); exa(132, 1'b1, "cont_on"); exa(133, 1'b0, "cont_off");
        exa(144, 1'b0, "cont_off"); exa(145, 1'b1, "cont_on2"); exa(156, 1'b1, "cont_on2");
        exa(157, 1'b0, "cont_off2"); exa(168, 1'b0, "cont_off2"); exa(169, 1'b1, "cont_on3");
        exa(180, 1'b1, "tail_flash"); exa(181, 1'b0, "tail_gap"); exa(192, 1'b0, "tail_gap");
        exa(193, 1'b1, "same_edge_pend"); exa(204, 1'b1, "tail_flash2");
        exa(205, 1'b0, "tail_gap2"); exa(217, 1'b0, "tail_idle"); exa(218, 1'b0, "tail_idle");
        go(169); evt[1] = 1'b0;

        go(221); mode[0] = 2'd0;
        ex(221, 2'b01, "pre_off"); ex(222, 2'b00, "mode_off");
        ex(224, 2'b00, "off_hold"); ex(225, 2'b01, "mode_on"); ex(230, 2'b01, "on_hold");
        go(224); mode[0] = 2'd1;

        go(230); mode[0] = 2'd2; hp[0] = 4'd2; mode[1] = 2'd0;
        ex(231, 2'b01, "indep_entry"); ex(235, 2'b01, "collision");
        ex(236, 2'b01, "collision_hold"); ex(237, 2'b00, "indep_blink");
        ex(239, 2'b10, "indep_flash"); ex(244, 2'b10, "indep_hold"); ex(245, 2'b11, "indep_both");
        go(234); mode[1] = 2'd3; evt[1] = 1'b1;
        go(235); evt[1] = 1'b0;
        go(238); evt[1] = 1'b1;
        go(239); evt[1] = 1'b0;

        // asynchronous reset between edges, mid-flash and mid-blink
        go(246);
        #2;
        rst = 1'b1; mode = '0; evt = '0;
        #1;
        push(246, 1'b1, 2'b00, 1'b1, 1'b0, "async_rst");
        -> sample_ev;
        go(247); rst = 1'b0;
        ext(248, 2'b00, 1'b0, "post_rst"); ext(250, 2'b00, 1'b0, "post_rst_tick");
        ext(251, 2'b00, 1'b1, "post_rst_tick_first");
        go(254);

        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left %0d want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
